// File: rtl/mat_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mat_mul_seq
//  Purpose  : Byte-stream operand collector and result sequencer for the
//             2x2 8-bit matrix-multiply core.
//  Revision : 1.0
// ============================================================================
module mat_mul_seq #(
   parameter int unsigned MM_LAT = 3,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       in_data_i,
   input  logic             in_valid_i,
   input  logic             in_sof_i,
   output logic             in_ready_o,
   output logic [31:0]      mm_a_o,
   output logic [31:0]      mm_b_o,
   output logic             mm_load_o,
   input  logic [31:0]      mm_res_i,
   output logic [31:0]      res_data_o,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic             busy_o,
   output logic             sync_err_o,
   output logic [CNT_W-1:0] op_count_o
);

   localparam int unsigned           WAIT_W    = (MM_LAT > 1) ? $clog2(MM_LAT) : 1;
   localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(MM_LAT - 1);
   localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t            state_q;
   logic [2:0]        elem_q;
   logic [WAIT_W-1:0] wait_q;
   logic [31:0]       mm_a_q;
   logic [31:0]       mm_b_q;
   logic              mm_load_q;
   logic [31:0]       res_data_q;
   logic              res_valid_q;
   logic              in_ready_q;
   logic              busy_q;
   logic              sync_err_q;
   logic [CNT_W-1:0]  op_count_q;

   logic              xfer_d;
   logic              res_hs_d;
   logic [4:0]        byte_lsb_d;

   assign xfer_d   = in_valid_i && in_ready_q;
   assign res_hs_d = res_valid_q && res_ready_i;
   // Element 0 of each operand lands in the top byte, element 3 in the bottom.
   assign byte_lsb_d = {~elem_q[1:0], 3'b000};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FILL;
         elem_q      <= 3'd0;
         wait_q      <= '0;
         mm_a_q      <= 32'd0;
         mm_b_q      <= 32'd0;
         mm_load_q   <= 1'b0;
         res_data_q  <= 32'd0;
         res_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         sync_err_q  <= 1'b0;
         op_count_q  <= '0;
      end else begin
         case (state_q)
            S_FILL: begin
               if (xfer_d) begin
                  if (in_sof_i) begin
                     // A start-of-frame always restarts the frame at A00.
                     mm_a_q[31:24] <= in_data_i;
                     elem_q        <= 3'd1;
                     if (elem_q != 3'd0) begin
                        sync_err_q <= 1'b1;
                     end
                  end else begin
                     if (!elem_q[2]) begin
                        mm_a_q[byte_lsb_d +: 8] <= in_data_i;
                     end else begin
                        mm_b_q[byte_lsb_d +: 8] <= in_data_i;
                     end
                     if (elem_q == 3'd7) begin
                        elem_q     <= 3'd0;
                        state_q    <= S_LOAD;
                        mm_load_q  <= 1'b1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                     end else begin
                        elem_q <= elem_q + 3'd1;
                     end
                  end
               end
            end
            S_LOAD: begin
               mm_load_q <= 1'b0;
               wait_q    <= '0;
               state_q   <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_q == WAIT_LAST) begin
                  res_data_q  <= mm_res_i;
                  res_valid_q <= 1'b1;
                  state_q     <= S_OUT;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            S_OUT: begin
               if (res_hs_d) begin
                  res_valid_q <= 1'b0;
                  op_count_q  <= op_count_q + CNT_ONE;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_FILL;
               end
            end
            default: begin
               state_q <= S_FILL;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign mm_a_o      = mm_a_q;
   assign mm_b_o      = mm_b_q;
   assign mm_load_o   = mm_load_q;
   assign res_data_o  = res_data_q;
   assign res_valid_o = res_valid_q;
   assign busy_o      = busy_q;
   assign sync_err_o  = sync_err_q;
   assign op_count_o  = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mat_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mat_mul_seq
//  Purpose  : Directed self-checking bench for mat_mul_seq with a behavioural
//             2x2 matrix-multiply core attached.
//  Revision : 1.0
// ============================================================================
module tb_mat_mul_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_valid = 1'b0;
   logic        in_sof = 1'b0;
   logic        in_ready;
   logic [31:0] mm_a;
   logic [31:0] mm_b;
   logic        mm_load;
   logic [31:0] mm_res;
   logic [31:0] res_data;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic        busy;
   logic        sync_err;
   logic [15:0] op_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mat_mul_seq #(.MM_LAT(3), .CNT_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_sof_i    (in_sof),
      .in_ready_o  (in_ready),
      .mm_a_o      (mm_a),
      .mm_b_o      (mm_b),
      .mm_load_o   (mm_load),
      .mm_res_i    (mm_res),
      .res_data_o  (res_data),
      .res_valid_o (res_valid),
      .res_ready_i (res_ready),
      .busy_o      (busy),
      .sync_err_o  (sync_err),
      .op_count_o  (op_count)
   );

   // Core model: result is valid from the third cycle after the load cycle.
   logic [31:0] core_prod = 32'd0;
   int          core_cnt  = 0;

   function automatic logic [31:0] matmul(input logic [31:0] a, input logic [31:0] b);
      logic [7:0] c00, c01, c10, c11;
      c00 = a[31:24] * b[31:24] + a[23:16] * b[15:8];
      c01 = a[31:24] * b[23:16] + a[23:16] * b[7:0];
      c10 = a[15:8]  * b[31:24] + a[7:0]   * b[15:8];
      c11 = a[15:8]  * b[23:16] + a[7:0]   * b[7:0];
      return {c00, c01, c10, c11};
   endfunction

   always @(posedge clk) begin
      if (mm_load) begin
         core_prod <= matmul(mm_a, mm_b);
         core_cnt  <= 1;
      end else if (core_cnt != 0 && core_cnt < 10) begin
         core_cnt <= core_cnt + 1;
      end
   end

   assign mm_res = (core_cnt >= 3) ? core_prod : 32'hDEAD_BEEF;

   task automatic send_frame(input logic [63:0] f, input bit bubbles);
      for (int i = 0; i < 8; i++) begin
         if (bubbles && i > 0) begin
            in_valid = 1'b0;
            in_data  = 8'hEE;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = f[63-8*i -: 8];
         in_sof   = (i == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic wait_result(output int lat, output bit ok);
      lat = 0;
      ok  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         lat++;
         if (res_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic accept_result(input logic [15:0] exp_cnt);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      n_checks++;
      if (op_count !== exp_cnt) begin
         n_errors++;
         $display("FAIL op_count: got %0d expected %0d", op_count, exp_cnt);
      end
      n_checks++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL post_handshake: valid=%b ready=%b busy=%b expected 0 1 0",
                  res_valid, in_ready, busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (mm_a !== 32'd0 || mm_b !== 32'd0 || res_data !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_data: a=%h b=%h res=%h expected all 0", mm_a, mm_b, res_data);
      end
      n_checks++;
      if (mm_load !== 1'b0 || res_valid !== 1'b0 || sync_err !== 1'b0 ||
          op_count !== 16'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_ctrl: load=%b valid=%b serr=%b cnt=%0d busy=%b ready=%b expected 0 0 0 0 0 1",
                  mm_load, res_valid, sync_err, op_count, busy, in_ready);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int lat;
      bit ok;
      send_frame(64'h01020304_05060708, 1'b0);
      n_checks++;
      if (mm_load !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL basic_load: load=%b ready=%b busy=%b expected 1 0 1", mm_load, in_ready, busy);
      end
      n_checks++;
      if (mm_a !== 32'h01020304 || mm_b !== 32'h05060708) begin
         n_errors++;
         $display("FAIL basic_operands: a=%h b=%h expected 01020304 05060708", mm_a, mm_b);
      end
      @(posedge clk); #1;
      n_checks++;
      if (mm_load !== 1'b0 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL basic_load_pulse: load=%b busy=%b expected 0 1", mm_load, busy);
      end
      wait_result(lat, ok);
      n_checks++;
      if (!ok || lat !== 3) begin
         n_errors++;
         $display("FAIL basic_latency: seen=%b cycles_after_load=%0d expected 4", ok, lat + 1);
      end
      n_checks++;
      if (res_data !== 32'h13162B32) begin
         n_errors++;
         $display("FAIL basic_result: got %h expected 13162b32", res_data);
      end
      accept_result(16'd1);
   endtask

   task automatic test_backpressure();
      int lat;
      bit ok;
      send_frame(64'h01020304_05060708, 1'b0);
      wait_result(lat, ok);
      n_checks++;
      if (!ok || lat !== 4) begin
         n_errors++;
         $display("FAIL bp_latency: seen=%b cycles=%0d expected 4", ok, lat);
      end
      in_valid = 1'b1;
      in_sof   = 1'b1;
      in_data  = 8'h55;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (in_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 32'h13162B32 ||
             op_count !== 16'd1) begin
            n_errors++;
            $display("FAIL bp_hold[%0d]: ready=%b valid=%b res=%h cnt=%0d expected 0 1 13162b32 1",
                     i, in_ready, res_valid, res_data, op_count);
         end
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      n_checks++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 16'd2) begin
         n_errors++;
         $display("FAIL bp_release: valid=%b ready=%b cnt=%0d expected 0 1 2", res_valid, in_ready, op_count);
      end
   endtask

   task automatic test_bubbles();
      int lat;
      bit ok;
      send_frame(64'h01020304_05060708, 1'b1);
      n_checks++;
      if (mm_load !== 1'b1 || mm_a !== 32'h01020304 || mm_b !== 32'h05060708) begin
         n_errors++;
         $display("FAIL bubble_operands: load=%b a=%h b=%h expected 1 01020304 05060708", mm_load, mm_a, mm_b);
      end
      wait_result(lat, ok);
      n_checks++;
      if (!ok || res_data !== 32'h13162B32) begin
         n_errors++;
         $display("FAIL bubble_result: seen=%b got %h expected 13162b32", ok, res_data);
      end
      accept_result(16'd3);
   endtask

   task automatic test_realign();
      int lat;
      bit ok;
      logic [23:0] junk;
      junk = 24'hAABBCC;
      n_checks++;
      if (sync_err !== 1'b0) begin
         n_errors++;
         $display("FAIL realign_pre: sync_err=%b expected 0", sync_err);
      end
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_sof   = (i == 0);
         in_data  = junk[23-8*i -: 8];
         @(posedge clk); #1;
      end
      send_frame(64'h02000002_01010101, 1'b0);
      n_checks++;
      if (sync_err !== 1'b1 || mm_load !== 1'b1) begin
         n_errors++;
         $display("FAIL realign_flag: sync_err=%b load=%b expected 1 1", sync_err, mm_load);
      end
      n_checks++;
      if (mm_a !== 32'h02000002 || mm_b !== 32'h01010101) begin
         n_errors++;
         $display("FAIL realign_operands: a=%h b=%h expected 02000002 01010101", mm_a, mm_b);
      end
      wait_result(lat, ok);
      n_checks++;
      if (!ok || res_data !== 32'h02020202) begin
         n_errors++;
         $display("FAIL realign_result: seen=%b got %h expected 02020202", ok, res_data);
      end
      accept_result(16'd4);
   endtask

   task automatic test_wrap();
      int lat;
      bit ok;
      send_frame({8{8'h10}}, 1'b0);
      wait_result(lat, ok);
      n_checks++;
      if (!ok || res_data !== 32'h00000000) begin
         n_errors++;
         $display("FAIL wrap_result: seen=%b got %h expected 00000000", ok, res_data);
      end
      accept_result(16'd5);
   endtask

   task automatic test_reset_mid_wait();
      int lat;
      bit ok;
      send_frame(64'h01020304_05060708, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      n_checks++;
      if (mm_a !== 32'd0 || mm_b !== 32'd0 || res_data !== 32'd0 || mm_load !== 1'b0 ||
          res_valid !== 1'b0 || sync_err !== 1'b0 || op_count !== 16'd0 ||
          busy !== 1'b0 || in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL midwait_async_reset: a=%h b=%h res=%h load=%b valid=%b serr=%b cnt=%0d busy=%b ready=%b",
                  mm_a, mm_b, res_data, mm_load, res_valid, sync_err, op_count, busy, in_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_frame(64'h01020304_05060708, 1'b0);
      wait_result(lat, ok);
      n_checks++;
      if (!ok || lat !== 4 || res_data !== 32'h13162B32) begin
         n_errors++;
         $display("FAIL midwait_recover: seen=%b cycles=%0d got %h expected 4 13162b32", ok, lat, res_data);
      end
      accept_result(16'd1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_bubbles();
      test_realign();
      test_wrap();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mat_mul_seq.md
Name: mat_mul_seq

Overview:
- Sequencer directly upstream and downstream of the 2x2 8-bit matrix-multiply core.
- Collects eight 8-bit elements from a valid/ready byte stream and packs them into the 32-bit A and B operand words.
- Pulses the core's active-high load input, waits a fixed compute latency, then captures the packed 32-bit result.
- Presents the result on a valid/ready output stream, one result per operand set.

Parameters:
- MM_LAT, 3: cycles after the load cycle before the core result is sampled. Must be ≥1. The value 3 matches the current core: Res is valid in the third cycle after load.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- in_data  in  8  operand element.
- in_valid  in  1  in_data valid.
- in_sof  in  1  start-of-frame; qualifies in_data as element 0 of A.
- in_ready  out  1  block accepts an element this cycle.
- mm_a  out  32  packed A to core: {A00,A01,A10,A11}.
- mm_b  out  32  packed B to core, same packing.
- mm_load  out  1  active-high load/clear pulse to the core.
- mm_res  in  32  packed result from the core.
- res_data  out  32  captured result.
- res_valid  out  1  res_data valid.
- res_ready  in  1  downstream accepts res_data.
- busy  out  1  high in the LOAD, WAIT and OUT states.
- sync_err  out  1  sticky; set on a frame realign.
- op_count  out  CNT_W  number of results accepted downstream.

Behaviour:
- Reset (async assert, registers released on the next clk edge after deassert):
  - state = FILL, element index = 0.
  - mm_a = mm_b = res_data = 0.
  - mm_load = 0, res_valid = 0, sync_err = 0, op_count = 0.
- A transfer occurs when in_valid && in_ready; a result handshake when res_valid && res_ready.
- FILL:
  - in_ready = 1.
  - Element index e runs 0..7. e=0..3 fill mm_a bytes [31:24], [23:16], [15:8], [7:0]. e=4..7 fill mm_b in the same order.
  - Each transfer writes its byte and increments e.
  - On the transfer with e=7: e -> 0, next state LOAD.
- in_sof:
  - With a transfer at e=0: normal.
  - With a transfer at e≠0: the byte is written as A00, e -> 1, sync_err set.
  - in_sof without in_valid: ignored.
- LOAD (exactly 1 cycle):
  - mm_load = 1 and in_ready = 0. mm_a and mm_b are stable.
  - Next state WAIT; wait counter = 0.
- WAIT:
  - Counter increments each cycle; lasts exactly MM_LAT cycles.
  - On the edge ending the last WAIT cycle: res_data <= mm_res, res_valid <= 1, next state OUT.
  - Latency: the load cycle is L; res_valid is first high in cycle L+MM_LAT+1.
- OUT:
  - res_data and res_valid are held until the result handshake.
  - On the handshake: res_valid -> 0, op_count +1 (wraps at 2^CNT_W), next state FILL.
  - in_ready stays 0 in OUT, so there is no overlap between a result and the next fill.
- mm_load is registered and high only in LOAD. mm_a and mm_b change only in FILL.
- in_valid, in_data and in_sof are don't-care outside FILL.
- Reset mid-operation in any state: immediate return to reset values. A partial frame is discarded and any pending result is lost.
- res_ready high while res_valid = 0: no effect.

Test Plan:
- Basic multiply:
  - Stimulus: reset, then stream 1,2,3,4,5,6,7,8 with in_sof on the first byte.
  - Response: mm_a=0x01020304, mm_b=0x05060708, one-cycle mm_load. With the real core attached, res_data=0x13162B32 (19,22,43,50) with res_valid first high 4 cycles after the load cycle; op_count=1 after res_ready.
- Backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles after res_valid rises; drive in_valid=1.
  - Response: in_ready=0, res_data stable, op_count unchanged; one cycle after res_ready=1, res_valid=0 and in_ready=1.
- Bubbles:
  - Stimulus: same 8 bytes with in_valid toggled every other cycle.
  - Response: identical mm_a/mm_b and result to the basic-multiply test.
- Realign:
  - Stimulus: send 3 bytes (0xAA,0xBB,0xCC), then in_sof with the 8 bytes 2,0,0,2,1,1,1,1.
  - Response: sync_err=1, mm_a=0x02000002, mm_b=0x01010101, res_data=0x02020202.
- Wrap:
  - Stimulus: 8-bit overflow operands 0x10 for every element.
  - Response: res_data=0x00000000 (16*16*2 = 512 mod 256).
- Reset mid-WAIT:
  - Stimulus: assert reset two cycles after mm_load.
  - Response: all outputs return to their reset values asynchronously. After release, a new frame of 1..8 produces 0x13162B32 again.
